oc8051_ecc_dec_stream: RTL and testbench
========================================

# oc8051_ecc_dec_stream

Multi-lane, pipelined SECDED (extended Hamming) decoder with a valid/ready streaming interface. It sits between ECC-protected memory read ports and the 8051 core and memory-scrub logic. Each beat carries LANES independent codewords plus an address tag. The block corrects single-bit errors, flags double-bit errors, keeps saturating error counters and holds a sticky log of the first uncorrectable error for software and interrupt use.

## Interface
Parameters:
- K, 8: information bits per lane
- LANES, 4: codewords per beat (≥1)
- TAGW, 16: address/tag width
- CNTW, 16: error-counter width
- P0_LSB, 1: 1 = overall parity bit at codeword LSB; 0 = at MSB
- derived (not overridable): m = smallest m with 2^m ≥ m+K+1; n = m+K; LW = max(1, clog2(LANES))

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o
- in_tag_i  in  TAGW  tag of beat
- in_data_i  in  LANES*(n+1)  codewords; lane j at bits [j*(n+1) +: n+1]
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream accepts
- out_tag_o  out  TAGW  tag passed through
- out_q_o  out  LANES*K  corrected data; lane j at [j*K +: K]
- out_sb_err_o  out  LANES  per-lane single-bit error (corrected)
- out_db_err_o  out  LANES  per-lane double-bit error (data not corrected)
- sb_cnt_o  out  CNTW  saturating count of corrected lanes
- db_cnt_o  out  CNTW  saturating count of uncorrectable lanes
- cnt_clr_i  in  1  clear both counters
- log_valid_o  out  1  sticky: uncorrectable error logged
- log_tag_o  out  TAGW  tag of logged beat
- log_lane_o  out  LW  lane index of logged error
- log_syndrome_o  out  m+1  {syndrome, parity} (P0_LSB=1) or {parity, syndrome}
- log_clr_i  in  1  clear log
- irq_o  out  1  equals log_valid_o

## Operation
- Per lane: if P0_LSB=0, rotate the codeword so the parity bit lands at index 0. parity = XOR of all n+1 bits. syndrome[p] = XOR of bits i (1..n) with bit p-1 of i set.
- sb_err = parity & (syndrome≠0). db_err = ~parity & (syndrome≠0).
- Correction: invert bit[syndrome] only when sb_err. Syndrome 0 with parity 1 marks a p0 error: sb_err=0, data unchanged. Syndrome > n with parity 1 is treated as db_err.
- Data bits come from the non-power-of-2 indices 1..n, in ascending order.
- Stage S1 registers the codewords, per-lane syndrome/parity and tag. Stage S2 registers corrected q, flags and tag.
- Stage advance: S2 loads when !s2_valid | out_ready_i. S1 loads when !s1_valid | S2 loads. in_ready_o = !s1_valid | S2 loads.
- Counters update on the output handshake only. They add popcount(out_sb_err_o) and popcount(out_db_err_o) and saturate at 2^CNTW−1.
- cnt_clr_i in the same cycle as a handshake: counters become 0 and that beat's errors are discarded.
- Log capture: on an output handshake with any db_err while log_valid_o=0, or with log_clr_i=1 asserted in that same cycle. It captures the tag, the lowest erroneous lane and that lane's syndrome. Capture wins over clear.
- log_clr_i without a capture sets log_valid_o to 0. Log fields are held, not zeroed.

## Timing
- Latency is 2 cycles from the input handshake to out_valid_o, with no backpressure. Throughput is 1 beat/cycle.
- out_* data, tag and flags stay stable while out_valid_o & !out_ready_i.
- in_ready_o is combinational from out_ready_i. No other combinational input-to-output path exists.
- Reset: all valids 0, in_ready_o=1 from the first cycle after reset, all data/tag/flag/counter/log outputs 0, irq_o=0.
- Reset asserted mid-stream drops all in-flight beats. Counters and log are not updated for dropped beats.

## Structure
- Package oc8051_ecc_pkg holds calculate_m(), the syndrome, correction and extract functions, and a lane-result struct {q, syndrome, parity, sb_err, db_err}.
- Sub-module oc8051_ecc_lane_dec is the combinational single-lane decode (syndrome/parity and correct/extract). It is generated LANES times. The pipeline, counters and log stay in the top module.

## Test plan
With K=8 (m=4, n=12), LANES=4, P0_LSB=1:
- All-zero codewords on all lanes, tag 0x1234, out_ready_i=1 -> out_q_o=0, no flags, out_tag_o=0x1234 exactly 2 cycles after accept.
- Lane 2 bit 3 flipped (cw 0x0008) -> lane 2 q=0x00, out_sb_err_o=4'b0100, syndrome 3, sb_cnt_o=1.
- Lane 1 bits 3 and 5 flipped (0x0028), tag 0xBEEF -> out_db_err_o=4'b0010, log_valid_o=irq_o=1, log_tag_o=0xBEEF, log_lane_o=1, log_syndrome_o=5'b01100. A later db beat leaves the log unchanged.
- Hold out_ready_i=0 for 5 cycles with a continuous input -> in_ready_o drops after 2 beats are accepted, no beat is lost or duplicated, and order is preserved.
- With sb_cnt_o preset near saturation (CNTW=4), feed 16 sb beats -> sb_cnt_o holds 15. cnt_clr_i together with an sb beat -> 0.
- log_clr_i together with a new db beat -> log holds the new tag. Assert rst_i with 2 beats in flight -> out_valid_o=0 next cycle and counters are 0.

Source files
------------

// File: rtl/oc8051_ecc_pkg.sv
// Shared SECDED helpers for the 8051 ECC read-path decoder.
// Functions work on maximum-width vectors; callers zero-extend and slice.
package oc8051_ecc_pkg;

  localparam int unsigned MaxK = 64;
  localparam int unsigned MaxM = 7;
  localparam int unsigned MaxN = MaxM + MaxK;

  typedef struct packed {
    logic [MaxK-1:0] q;
    logic [MaxM-1:0] syndrome;
    logic            parity;
    logic            sb_err;
    logic            db_err;
  } lane_res_t;

  // Smallest m with 2^m >= m + k + 1.
  function automatic int unsigned calculate_m(int unsigned k);
    int unsigned m;
    m = 0;
    for (int unsigned i = 1; i < 32; i++) begin
      if (m == 0 && (32'd1 << i) >= i + k + 1) m = i;
    end
    return m;
  endfunction

  // Bit p of the syndrome covers every position whose index has bit p set.
  function automatic logic [MaxM-1:0] calc_syndrome(logic [MaxN:0] cw, int unsigned n);
    logic [MaxM-1:0] syn;
    syn = '0;
    for (int unsigned i = 1; i <= MaxN; i++) begin
      if (i <= n) begin
        for (int unsigned p = 0; p < MaxM; p++) begin
          if (i[p]) syn[p] = syn[p] ^ cw[i];
        end
      end
    end
    return syn;
  endfunction

  function automatic logic [MaxN:0] correct_cw(logic [MaxN:0] cw, logic [MaxM-1:0] syn,
                                               logic sb);
    logic [MaxN:0] flip;
    flip = '0;
    if (sb) flip[syn] = 1'b1;
    return cw ^ flip;
  endfunction

  // Data bits live at the non-power-of-2 positions, packed in ascending order.
  function automatic logic [MaxK-1:0] extract_data(logic [MaxN:0] cw, int unsigned n);
    logic [MaxK-1:0] q;
    int unsigned     k;
    q = '0;
    k = 0;
    for (int unsigned i = 1; i <= MaxN; i++) begin
      if (i <= n && (i & (i - 1)) != 0) begin
        if (k < MaxK) q[k] = cw[i];
        k++;
      end
    end
    return q;
  endfunction

  function automatic lane_res_t decode_lane(logic [MaxN:0] cw, logic [MaxM-1:0] syn,
                                            logic parity, int unsigned n);
    lane_res_t res;
    logic      nz;
    logic      in_range;
    nz           = (syn != '0);
    in_range     = (32'(syn) <= n);
    res.syndrome = syn;
    res.parity   = parity;
    // Odd parity with a syndrome pointing outside the codeword cannot be a single flip.
    res.sb_err   = parity & nz & in_range;
    res.db_err   = nz & (~parity | ~in_range);
    res.q        = extract_data(correct_cw(cw, syn, res.sb_err), n);
    return res;
  endfunction

endpackage

// File: rtl/oc8051_ecc_lane_dec.sv
// Combinational single-lane SECDED decode. The front half (syndrome/parity)
// feeds stage S1; the back half (correct/extract) works on S1 contents.
module oc8051_ecc_lane_dec
  import oc8051_ecc_pkg::*;
#(
  parameter int unsigned K      = 8,
  parameter int unsigned P0_LSB = 1,
  localparam int unsigned M     = calculate_m(K),
  localparam int unsigned N     = M + K
) (
  input  logic [N:0]   cw,
  output logic [N:0]   cw_rot,
  output logic [M-1:0] syndrome,
  output logic         parity,
  input  logic [N:0]   s1_cw,
  input  logic [M-1:0] s1_syndrome,
  input  logic         s1_parity,
  output logic [K-1:0] q,
  output logic         sb_err,
  output logic         db_err
);

  logic [MaxM-1:0] syn_full;
  lane_res_t       res;
  logic            unused_res;

  // Move the overall parity bit to index 0, then compute syndrome and parity.
  always_comb begin
    if (P0_LSB != 0) cw_rot = cw;
    else             cw_rot = {cw[N-1:0], cw[N]};
    parity   = ^cw;
    syn_full = calc_syndrome((MaxN+1)'(cw_rot), N);
    syndrome = syn_full[M-1:0];
  end

  // Correct and extract from the registered S1 codeword.
  always_comb begin
    res    = decode_lane((MaxN+1)'(s1_cw), MaxM'(s1_syndrome), s1_parity, N);
    q      = res.q[K-1:0];
    sb_err = res.sb_err;
    db_err = res.db_err;
  end

  assign unused_res = ^{res, syn_full};

endmodule

// File: rtl/oc8051_ecc_dec_stream.sv
// Multi-lane pipelined SECDED decoder with valid/ready streaming, saturating
// error counters and a sticky log of the first uncorrectable error.
module oc8051_ecc_dec_stream
  import oc8051_ecc_pkg::*;
#(
  parameter int unsigned K      = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned TAGW   = 16,
  parameter int unsigned CNTW   = 16,
  parameter int unsigned P0_LSB = 1,
  localparam int unsigned M     = calculate_m(K),
  localparam int unsigned N     = M + K,
  localparam int unsigned CW    = N + 1,
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [TAGW-1:0]     in_tag_i,
  input  logic [LANES*CW-1:0] in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [TAGW-1:0]     out_tag_o,
  output logic [LANES*K-1:0]  out_q_o,
  output logic [LANES-1:0]    out_sb_err_o,
  output logic [LANES-1:0]    out_db_err_o,
  output logic [CNTW-1:0]     sb_cnt_o,
  output logic [CNTW-1:0]     db_cnt_o,
  input  logic                cnt_clr_i,
  output logic                log_valid_o,
  output logic [TAGW-1:0]     log_tag_o,
  output logic [LW-1:0]       log_lane_o,
  output logic [M:0]          log_syndrome_o,
  input  logic                log_clr_i,
  output logic                irq_o
);

  logic s1_load, s2_load, in_fire, out_fire;

  logic [LANES-1:0][N:0]   cw_rot;
  logic [LANES-1:0][M-1:0] syn;
  logic [LANES-1:0]        par;

  logic                    s1_valid;
  logic [TAGW-1:0]         s1_tag;
  logic [LANES-1:0][N:0]   s1_cw;
  logic [LANES-1:0][M-1:0] s1_syn;
  logic [LANES-1:0]        s1_par;
  logic [LANES-1:0][M:0]   s1_log_syn;

  logic [LANES*K-1:0]      dec_q;
  logic [LANES-1:0]        dec_sb, dec_db;

  logic                    s2_valid;
  logic [TAGW-1:0]         s2_tag;
  logic [LANES*K-1:0]      s2_q;
  logic [LANES-1:0]        s2_sb, s2_db;
  logic [LANES-1:0][M:0]   s2_syn;

  logic [CNTW-1:0]         sb_cnt, db_cnt, sb_cnt_nxt, db_cnt_nxt;

  logic                    log_valid, log_capture;
  logic [TAGW-1:0]         log_tag;
  logic [LW-1:0]           log_lane, log_sel;
  logic [M:0]              log_syn;

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    oc8051_ecc_lane_dec #(
      .K      (K),
      .P0_LSB (P0_LSB)
    ) u_lane (
      .cw          (in_data_i[j*CW +: CW]),
      .cw_rot      (cw_rot[j]),
      .syndrome    (syn[j]),
      .parity      (par[j]),
      .s1_cw       (s1_cw[j]),
      .s1_syndrome (s1_syn[j]),
      .s1_parity   (s1_par[j]),
      .q           (dec_q[j*K +: K]),
      .sb_err      (dec_sb[j]),
      .db_err      (dec_db[j])
    );
    assign s1_log_syn[j] = (P0_LSB != 0) ? {s1_syn[j], s1_par[j]} : {s1_par[j], s1_syn[j]};
  end

  assign s2_load    = ~s2_valid | out_ready_i;
  assign s1_load    = ~s1_valid | s2_load;
  assign in_ready_o = s1_load;
  assign in_fire    = in_valid_i & s1_load;
  assign out_fire   = s2_valid & out_ready_i;

  // S1: rotated codewords, syndrome/parity and tag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_cw    <= '0;
      s1_syn   <= '0;
      s1_par   <= '0;
    end else begin
      if (s1_load) s1_valid <= in_valid_i;
      if (in_fire) begin
        s1_tag <= in_tag_i;
        s1_cw  <= cw_rot;
        s1_syn <= syn;
        s1_par <= par;
      end
    end
  end

  // S2: corrected data, flags, log-format syndromes and tag; held under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_tag   <= '0;
      s2_q     <= '0;
      s2_sb    <= '0;
      s2_db    <= '0;
      s2_syn   <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_tag <= s1_tag;
        s2_q   <= dec_q;
        s2_sb  <= dec_sb;
        s2_db  <= dec_db;
        s2_syn <= s1_log_syn;
      end
    end
  end

  // Saturating counter increments and lowest failing lane for the log.
  always_comb begin
    sb_cnt_nxt = sb_cnt;
    db_cnt_nxt = db_cnt;
    log_sel    = '0;
    for (int j = 0; j < LANES; j++) begin
      if (s2_sb[j] && sb_cnt_nxt != '1) sb_cnt_nxt = sb_cnt_nxt + CNTW'(1);
      if (s2_db[j] && db_cnt_nxt != '1) db_cnt_nxt = db_cnt_nxt + CNTW'(1);
    end
    for (int j = LANES - 1; j >= 0; j--) begin
      if (s2_db[j]) log_sel = LW'(j);
    end
    log_capture = out_fire & (|s2_db) & (~log_valid | log_clr_i);
  end

  // Counters; a clear discards the errors of a beat leaving in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      sb_cnt <= '0;
      db_cnt <= '0;
    end else if (out_fire) begin
      sb_cnt <= sb_cnt_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  // Sticky log; capture takes priority over clear, fields hold after clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      log_valid <= 1'b0;
      log_tag   <= '0;
      log_lane  <= '0;
      log_syn   <= '0;
    end else if (log_capture) begin
      log_valid <= 1'b1;
      log_tag   <= s2_tag;
      log_lane  <= log_sel;
      log_syn   <= s2_syn[log_sel];
    end else if (log_clr_i) begin
      log_valid <= 1'b0;
    end
  end

  assign out_valid_o    = s2_valid;
  assign out_tag_o      = s2_tag;
  assign out_q_o        = s2_q;
  assign out_sb_err_o   = s2_sb;
  assign out_db_err_o   = s2_db;
  assign sb_cnt_o       = sb_cnt;
  assign db_cnt_o       = db_cnt;
  assign log_valid_o    = log_valid;
  assign log_tag_o      = log_tag;
  assign log_lane_o     = log_lane;
  assign log_syndrome_o = log_syn;
  assign irq_o          = log_valid;

endmodule

// File: tb/tb_oc8051_ecc_dec_stream.sv
// Directed bench for oc8051_ecc_dec_stream: K=8 (n=12), 4 lanes, 4-bit counters.
module tb_oc8051_ecc_dec_stream;

  localparam int unsigned CW = 13;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_tag;
  logic [51:0] in_data;
  logic        out_valid, out_ready;
  logic [15:0] out_tag;
  logic [31:0] out_q;
  logic [3:0]  out_sb, out_db;
  logic [3:0]  sb_cnt, db_cnt;
  logic        cnt_clr, log_clr;
  logic        log_valid, irq;
  logic [15:0] log_tag;
  logic [1:0]  log_lane;
  logic [4:0]  log_syn;

  int checks   = 0;
  int failures = 0;
  int sb_exp   = 0;
  int db_exp   = 0;

  typedef struct {
    logic [15:0] tag;
    logic [51:0] data;
    logic [31:0] q;
    logic [3:0]  sb;
    logic [3:0]  db;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  oc8051_ecc_dec_stream #(
    .K(8), .LANES(4), .TAGW(16), .CNTW(4), .P0_LSB(1)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_tag_i       (in_tag),
    .in_data_i      (in_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_tag_o      (out_tag),
    .out_q_o        (out_q),
    .out_sb_err_o   (out_sb),
    .out_db_err_o   (out_db),
    .sb_cnt_o       (sb_cnt),
    .db_cnt_o       (db_cnt),
    .cnt_clr_i      (cnt_clr),
    .log_valid_o    (log_valid),
    .log_tag_o      (log_tag),
    .log_lane_o     (log_lane),
    .log_syndrome_o (log_syn),
    .log_clr_i      (log_clr),
    .irq_o          (irq)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_add(int c, int a);
    return (c + a > 15) ? 15 : c + a;
  endfunction

  // One isolated beat: accept, check 2-cycle latency and outputs, then counters.
  task automatic send_beat(input logic [15:0] tag, input logic [51:0] data,
                           input logic [31:0] q, input logic [3:0] sb, input logic [3:0] db,
                           input bit clr_log, input bit clr_cnt);
    in_valid = 1'b1;
    in_tag   = tag;
    in_data  = data;
    #1;
    check("accept_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    in_tag   = '0;
    in_data  = '0;
    check("latency_not_early", 64'(out_valid), 64'd0);
    tick();
    check("out_valid", 64'(out_valid), 64'd1);
    check("out_tag", 64'(out_tag), 64'(tag));
    check("out_q", 64'(out_q), 64'(q));
    check("out_sb", 64'(out_sb), 64'(sb));
    check("out_db", 64'(out_db), 64'(db));
    log_clr = clr_log;
    cnt_clr = clr_cnt;
    tick();
    log_clr = 1'b0;
    cnt_clr = 1'b0;
    if (clr_cnt) begin
      sb_exp = 0;
      db_exp = 0;
    end else begin
      sb_exp = sat_add(sb_exp, $countones(sb));
      db_exp = sat_add(db_exp, $countones(db));
    end
    check("sb_cnt", 64'(sb_cnt), 64'(sb_exp));
    check("db_cnt", 64'(db_cnt), 64'(db_exp));
    check("out_drained", 64'(out_valid), 64'd0);
  endtask

  // Continuous stream of num beats; optional 5-cycle output stall at the start.
  task automatic stream(input int num, input logic [15:0] base, input logic [12:0] cw0,
                        input logic [7:0] q0, input bit sb0, input bit stall);
    int sent = 0;
    int recv = 0;
    int cyc  = 0;
    bit acc;
    while (recv < num && cyc < 100) begin
      in_valid  = (sent < num);
      in_tag    = base + 16'(sent);
      in_data   = {39'd0, cw0};
      out_ready = stall ? (cyc >= 5) : 1'b1;
      #1;
      if (stall && cyc == 4) begin
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_accepted", 64'(sent), 64'd2);
        check("stall_hold_valid", 64'(out_valid), 64'd1);
        check("stall_hold_tag", 64'(out_tag), 64'(base));
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check("stream_order", 64'(out_tag), 64'(base + 16'(recv)));
        check("stream_q0", 64'(out_q[7:0]), 64'(q0));
        if (sb0) sb_exp = sat_add(sb_exp, 1);
        recv++;
      end
      tick();
      if (acc) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 64'(recv), 64'(num));
    check("stream_sb_cnt", 64'(sb_cnt), 64'(sb_exp));
    check("stream_db_cnt", 64'(db_cnt), 64'(db_exp));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Lane order in data/q literals is {lane3, lane2, lane1, lane0}.
    vecs[0] = '{16'h1234, {4{13'h0000}}, 32'h0, 4'b0000, 4'b0000};
    vecs[1] = '{16'h0001, {13'h0000, 13'h0008, 13'h0000, 13'h0000}, 32'h0,
                4'b0100, 4'b0000};
    vecs[2] = '{16'h0002, {13'h0000, 13'h000F, 13'h1EEE, 13'h144E}, 32'h0001FFA5,
                4'b0000, 4'b0000};
    vecs[3] = '{16'h0003, {13'h1CEE, 13'h100F, 13'h1EEF, 13'h146E}, 32'hFF01FFA5,
                4'b1101, 4'b0000};
    vecs[4] = '{16'h0004, {13'h0000, 13'h0000, 13'h0000, 13'h145E}, 32'h000000A5,
                4'b0001, 4'b0000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_tag    = '0;
    in_data   = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    log_clr   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_q", 64'(out_q), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_sb_cnt", 64'(sb_cnt), 64'd0);
    check("rst_db_cnt", 64'(db_cnt), 64'd0);
    check("rst_log_valid", 64'(log_valid), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_log_tag", 64'(log_tag), 64'd0);

    for (int i = 0; i < 5; i++) begin
      send_beat(vecs[i].tag, vecs[i].data, vecs[i].q, vecs[i].sb, vecs[i].db, 1'b0, 1'b0);
    end

    // First double error: lane 1 bits 3 and 5 -> syndrome 6, parity 0.
    send_beat(16'hBEEF, {13'h0000, 13'h0000, 13'h0028, 13'h0000}, 32'h00000300,
              4'b0000, 4'b0010, 1'b0, 1'b0);
    check("log_valid_a", 64'(log_valid), 64'd1);
    check("irq_a", 64'(irq), 64'd1);
    check("log_tag_a", 64'(log_tag), 64'hBEEF);
    check("log_lane_a", 64'(log_lane), 64'd1);
    check("log_syn_a", 64'(log_syn), 64'(5'b01100));

    // Later db beat (lane 0 three-bit error: syndrome 15 > n) must not touch the log.
    send_beat(16'h0BAD, {13'h0028, 13'h0000, 13'h0000, 13'h1006}, 32'h03000080,
              4'b0000, 4'b1001, 1'b0, 1'b0);
    check("log_tag_keep", 64'(log_tag), 64'hBEEF);
    check("log_lane_keep", 64'(log_lane), 64'd1);
    check("log_syn_keep", 64'(log_syn), 64'(5'b01100));

    // Clear together with a new db beat: capture wins.
    send_beat(16'hCAFE, {13'h0000, 13'h0000, 13'h0000, 13'h1006}, 32'h00000080,
              4'b0000, 4'b0001, 1'b1, 1'b0);
    check("log_valid_c", 64'(log_valid), 64'd1);
    check("log_tag_c", 64'(log_tag), 64'hCAFE);
    check("log_lane_c", 64'(log_lane), 64'd0);
    check("log_syn_c", 64'(log_syn), 64'(5'b11111));

    // Clear alone drops valid but holds the fields.
    log_clr = 1'b1;
    tick();
    log_clr = 1'b0;
    check("log_clr_valid", 64'(log_valid), 64'd0);
    check("log_clr_irq", 64'(irq), 64'd0);
    check("log_clr_tag_held", 64'(log_tag), 64'hCAFE);

    stream(8, 16'h0100, 13'h144E, 8'hA5, 1'b0, 1'b1);
    stream(16, 16'h0200, 13'h0008, 8'h00, 1'b1, 1'b0);
    check("sb_saturated", 64'(sb_cnt), 64'd15);

    send_beat(16'h7777, {13'h0000, 13'h0028, 13'h0000, 13'h0000}, 32'h00030000,
              4'b0000, 4'b0100, 1'b0, 1'b0);
    check("log_tag_d", 64'(log_tag), 64'h7777);
    check("log_lane_d", 64'(log_lane), 64'd2);

    // Reset with two beats in flight.
    in_valid = 1'b1;
    in_tag   = 16'h0D0D;
    in_data  = {39'd0, 13'h0008};
    tick();
    in_tag = 16'h0D0E;
    tick();
    in_valid = 1'b0;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sb_cnt", 64'(sb_cnt), 64'd0);
    check("mid_rst_db_cnt", 64'(db_cnt), 64'd0);
    check("mid_rst_log_valid", 64'(log_valid), 64'd0);
    rst = 1'b0;
    sb_exp = 0;
    db_exp = 0;
    tick();
    check("post_rst_no_ghost", 64'(out_valid), 64'd0);
    tick();
    check("post_rst_no_ghost2", 64'(out_valid), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Counter clear coinciding with an sb beat discards that beat's errors.
    send_beat(16'h0005, {13'h1CEE, 13'h100F, 13'h1EEF, 13'h146E}, 32'hFF01FFA5,
              4'b1101, 4'b0000, 1'b0, 1'b0);
    send_beat(16'h0006, {13'h0000, 13'h0000, 13'h0000, 13'h145E}, 32'h000000A5,
              4'b0001, 4'b0000, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
